// File: rtl/alu_core.sv
// Registered 32-bit integer ALU for the EXE stage: shifts, LUI, HI/LO moves,
// single-cycle multiply/divide and arithmetic/logic ops, all outputs registered.
module alu_core (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  input  logic [31:0] OperandA_IN,
  input  logic [31:0] OperandB_IN,
  input  logic [5:0]  ALUControl_IN,
  input  logic [4:0]  ShiftAmount_IN,
  output logic [31:0] ALUResult_OUT,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  typedef enum logic [5:0] {
    OP_SLL   = 6'b000000,
    OP_SRL   = 6'b000010,
    OP_SRA   = 6'b000011,
    OP_SLLV  = 6'b000100,
    OP_SRLV  = 6'b000110,
    OP_SRAV  = 6'b000111,
    OP_LUI   = 6'b001111,
    OP_MFHI  = 6'b010000,
    OP_MTHI  = 6'b010001,
    OP_MFLO  = 6'b010010,
    OP_MTLO  = 6'b010011,
    OP_MULT  = 6'b011000,
    OP_MULTU = 6'b011001,
    OP_DIV   = 6'b011010,
    OP_DIVU  = 6'b011011,
    OP_ADD   = 6'b100000,
    OP_ADDU  = 6'b100001,
    OP_SUB   = 6'b100010,
    OP_SUBU  = 6'b100011,
    OP_AND   = 6'b100100,
    OP_OR    = 6'b100101,
    OP_XOR   = 6'b100110,
    OP_NOR   = 6'b100111,
    OP_SLT   = 6'b101010,
    OP_SLTU  = 6'b101011
  } aluOp_e;

  logic [31:0] opA, opB;
  logic [4:0]  varShift;
  logic [63:0] prodSigned, prodUnsigned;
  logic        divZero, divOverflow;
  logic [31:0] divisor;
  logic signed [31:0] quotSigned, remSigned;
  logic [31:0] quotUnsigned, remUnsigned;
  logic [31:0] resultNext, hiNext, loNext;

  assign opA      = OperandA_IN;
  assign opB      = OperandB_IN;
  assign varShift = opA[4:0];

  assign prodSigned   = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
  assign prodUnsigned = {32'b0, opA} * {32'b0, opB};

  // Zero and 0x80000000/-1 divisors are swapped for 1: the zero case is
  // overridden below, and A/1 already yields quotient 0x80000000, remainder 0.
  assign divZero     = (opB == '0);
  assign divOverflow = (opA == 32'h8000_0000) && (opB == '1);
  assign divisor     = (divZero || divOverflow) ? 32'd1 : opB;

  assign quotSigned   = $signed(opA) / $signed(divisor);
  assign remSigned    = $signed(opA) % $signed(divisor);
  assign quotUnsigned = opA / divisor;
  assign remUnsigned  = opA % divisor;

  always_comb begin
    resultNext = '0;
    hiNext     = HI_IN;
    loNext     = LO_IN;
    case (ALUControl_IN)
      OP_SLL:   resultNext = opB << ShiftAmount_IN;
      OP_SRL:   resultNext = opB >> ShiftAmount_IN;
      OP_SRA:   resultNext = $signed(opB) >>> ShiftAmount_IN;
      OP_SLLV:  resultNext = opB << varShift;
      OP_SRLV:  resultNext = opB >> varShift;
      OP_SRAV:  resultNext = $signed(opB) >>> varShift;
      OP_LUI:   resultNext = {opB[15:0], 16'h0000};
      OP_MFHI:  resultNext = HI_IN;
      OP_MTHI:  hiNext     = opA;
      OP_MFLO:  resultNext = LO_IN;
      OP_MTLO:  loNext     = opA;
      OP_MULT:  {hiNext, loNext} = prodSigned;
      OP_MULTU: {hiNext, loNext} = prodUnsigned;
      OP_DIV: begin
        hiNext = divZero ? opA : remSigned;
        loNext = divZero ? '1  : quotSigned;
      end
      OP_DIVU: begin
        hiNext = divZero ? opA : remUnsigned;
        loNext = divZero ? '1  : quotUnsigned;
      end
      OP_ADD, OP_ADDU: resultNext = opA + opB;
      OP_SUB, OP_SUBU: resultNext = opA - opB;
      OP_AND:   resultNext = opA & opB;
      OP_OR:    resultNext = opA | opB;
      OP_XOR:   resultNext = opA ^ opB;
      OP_NOR:   resultNext = ~(opA | opB);
      OP_SLT:   resultNext = {31'b0, $signed(opA) < $signed(opB)};
      OP_SLTU:  resultNext = {31'b0, opA < opB};
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ALUResult_OUT <= '0;
      HI_OUT        <= '0;
      LO_OUT        <= '0;
    end else begin
      ALUResult_OUT <= resultNext;
      HI_OUT        <= hiNext;
      LO_OUT        <= loNext;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases from the operation table
// plus randomized traffic checked against a behavioural arithmetic model.
module tb_alu_core;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] HI_IN = '0, LO_IN = '0;
  logic [31:0] OperandA_IN = '0, OperandB_IN = '0;
  logic [5:0]  ALUControl_IN = '0;
  logic [4:0]  ShiftAmount_IN = '0;
  logic [31:0] ALUResult_OUT, HI_OUT, LO_OUT;

  int nChecks = 0;
  int nFails  = 0;

  alu_core dut (
    .CLOCK(CLOCK), .RESET(RESET), .HI_IN(HI_IN), .LO_IN(LO_IN),
    .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
    .ALUControl_IN(ALUControl_IN), .ShiftAmount_IN(ShiftAmount_IN),
    .ALUResult_OUT(ALUResult_OUT), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: plain integer arithmetic on the operation table.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, b, hi, lo,
                                input logic [4:0] sh,
                                output logic [31:0] r, h, l);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [4:0]      s;
    logic [31:0]     fill;
    r = 0; h = hi; l = lo;
    sa = longint'(int'(a)); sb = longint'(int'(b));
    ua = {32'b0, a};        ub = {32'b0, b};
    s  = (op == 6'd4 || op == 6'd6 || op == 6'd7) ? a[4:0] : sh;
    fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (op)
      6'd0, 6'd4: r = b << s;
      6'd2, 6'd6: r = b >> s;
      6'd3, 6'd7: r = (b >> s) | fill;
      6'd15: r = (b & 32'hFFFF) * 32'd65536;
      6'd16: r = hi;
      6'd17: h = a;
      6'd18: r = lo;
      6'd19: l = a;
      6'd24: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      6'd25: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      6'd26: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
      end
      6'd27: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
      6'd32, 6'd33: r = a + b;
      6'd34, 6'd35: r = a - b;
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd38: r = a ^ b;
      6'd39: r = ~(a | b);
      6'd42: r = (sa < sb) ? 32'd1 : 32'd0;
      6'd43: r = (ua < ub) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endfunction

  task automatic apply(input logic [5:0] op, input logic [31:0] a, b,
                       input logic [4:0] sh, input logic [31:0] hi, lo);
    ALUControl_IN = op; OperandA_IN = a; OperandB_IN = b;
    ShiftAmount_IN = sh; HI_IN = hi; LO_IN = lo;
    @(posedge CLOCK); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    nChecks++;
    if ({ALUResult_OUT, HI_OUT, LO_OUT} !== 96'h0) begin
      nFails++;
      $display("FAIL reset_hold: got %h %h %h want 0 0 0", ALUResult_OUT, HI_OUT, LO_OUT);
    end
    RESET = 1'b0;
    apply(6'd33, 32'h1234, 32'h1, 5'd0, 32'hAAAA_0001, 32'hBBBB_0002);
    nChecks++;
    if (ALUResult_OUT !== 32'h1235 || HI_OUT !== 32'hAAAA_0001 || LO_OUT !== 32'hBBBB_0002) begin
      nFails++;
      $display("FAIL pre_reset_load: got %h %h %h want 00001235 aaaa0001 bbbb0002",
               ALUResult_OUT, HI_OUT, LO_OUT);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    nChecks++;
    if ({ALUResult_OUT, HI_OUT, LO_OUT} !== 96'h0) begin
      nFails++;
      $display("FAIL async_reset: got %h %h %h want 0 0 0", ALUResult_OUT, HI_OUT, LO_OUT);
    end
    @(posedge CLOCK); #1;
    nChecks++;
    if ({ALUResult_OUT, HI_OUT, LO_OUT} !== 96'h0) begin
      nFails++;
      $display("FAIL reset_edge_ignored: got %h %h %h want 0 0 0", ALUResult_OUT, HI_OUT, LO_OUT);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic test_add();
    apply(6'd32, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h1111_1111, 32'h2222_2222);
    nChecks++;
    if (ALUResult_OUT !== 32'h8000_0000 || HI_OUT !== 32'h1111_1111 || LO_OUT !== 32'h2222_2222) begin
      nFails++;
      $display("FAIL add_wrap: got %h %h %h want 80000000 11111111 22222222",
               ALUResult_OUT, HI_OUT, LO_OUT);
    end
  endtask

  task automatic test_shifts();
    logic [5:0]  ops [4] = '{6'd0, 6'd2, 6'd3, 6'd7};
    logic [31:0] exp [4] = '{32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'hF800_0001};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], 32'd36, 32'h8000_0010, (ops[i] == 6'd7) ? 5'd0 : 5'd4, 32'h0, 32'h0);
      nChecks++;
      if (ALUResult_OUT !== exp[i]) begin
        nFails++;
        $display("FAIL shift_op%0d: got %h want %h", ops[i], ALUResult_OUT, exp[i]);
      end
    end
  endtask

  task automatic test_compare_lui();
    apply(6'd42, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    nChecks++;
    if (ALUResult_OUT !== 32'd1) begin
      nFails++; $display("FAIL slt: got %h want 00000001", ALUResult_OUT);
    end
    apply(6'd43, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    nChecks++;
    if (ALUResult_OUT !== 32'd0) begin
      nFails++; $display("FAIL sltu: got %h want 00000000", ALUResult_OUT);
    end
    apply(6'd15, 32'h5, 32'h0000_ABCD, 5'd0, 32'h0, 32'h0);
    nChecks++;
    if (ALUResult_OUT !== 32'hABCD_0000) begin
      nFails++; $display("FAIL lui: got %h want abcd0000", ALUResult_OUT);
    end
  endtask

  task automatic test_mult();
    apply(6'd24, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h5, 32'h6);
    nChecks++;
    if (HI_OUT !== 32'hFFFF_FFFF || LO_OUT !== 32'hFFFF_FFFA || ALUResult_OUT !== 32'h0) begin
      nFails++;
      $display("FAIL mult: got r=%h hi=%h lo=%h want 0 ffffffff fffffffa", ALUResult_OUT, HI_OUT, LO_OUT);
    end
    apply(6'd25, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h5, 32'h6);
    nChecks++;
    if (HI_OUT !== 32'h2 || LO_OUT !== 32'hFFFF_FFFA || ALUResult_OUT !== 32'h0) begin
      nFails++;
      $display("FAIL multu: got r=%h hi=%h lo=%h want 0 00000002 fffffffa", ALUResult_OUT, HI_OUT, LO_OUT);
    end
  endtask

  task automatic test_div();
    logic [5:0]  ops [3] = '{6'd26, 6'd27, 6'd26};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eLo [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eHi [3] = '{32'hFFFF_FFFF, 32'd7, 32'h0};
    for (int i = 0; i < 3; i++) begin
      apply(ops[i], as[i], bs[i], 5'd0, 32'h1234, 32'h5678);
      nChecks++;
      if (LO_OUT !== eLo[i] || HI_OUT !== eHi[i] || ALUResult_OUT !== 32'h0) begin
        nFails++;
        $display("FAIL div_case%0d: got r=%h hi=%h lo=%h want 0 %h %h",
                 i, ALUResult_OUT, HI_OUT, LO_OUT, eHi[i], eLo[i]);
      end
    end
  endtask

  task automatic test_moves();
    apply(6'd17, 32'd5, 32'h0, 5'd0, 32'hDEAD_0000, 32'hBEEF_0000);
    nChecks++;
    if (HI_OUT !== 32'd5 || LO_OUT !== 32'hBEEF_0000 || ALUResult_OUT !== 32'h0) begin
      nFails++;
      $display("FAIL mthi: got r=%h hi=%h lo=%h want 0 00000005 beef0000", ALUResult_OUT, HI_OUT, LO_OUT);
    end
    apply(6'd18, 32'h1, 32'h2, 5'd0, 32'h3, 32'd9);
    nChecks++;
    if (ALUResult_OUT !== 32'd9) begin
      nFails++; $display("FAIL mflo: got %h want 00000009", ALUResult_OUT);
    end
    apply(6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hCAFE_0001, 32'hF00D_0002);
    nChecks++;
    if (ALUResult_OUT !== 32'h0 || HI_OUT !== 32'hCAFE_0001 || LO_OUT !== 32'hF00D_0002) begin
      nFails++;
      $display("FAIL undefined_op: got r=%h hi=%h lo=%h want 0 cafe0001 f00d0002", ALUResult_OUT, HI_OUT, LO_OUT);
    end
  endtask

  // HI/LO fed back from the outputs must hold through non-HI/LO operations.
  task automatic test_back_to_back();
    apply(6'd17, 32'h0BAD_F00D, 32'h0, 5'd0, 32'h0, 32'h0);
    apply(6'd19, 32'h1357_9BDF, 32'h0, 5'd0, HI_OUT, LO_OUT);
    for (int i = 0; i < 4; i++)
      apply(6'd32 + 6'(i), $urandom, $urandom, 5'd0, HI_OUT, LO_OUT);
    nChecks++;
    if (HI_OUT !== 32'h0BAD_F00D || LO_OUT !== 32'h1357_9BDF) begin
      nFails++;
      $display("FAIL feedback_hold: got hi=%h lo=%h want 0badf00d 13579bdf", HI_OUT, LO_OUT);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] codes [26] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd15, 6'd16, 6'd17,
                               6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd33,
                               6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd1};
    logic [5:0]  op;
    logic [31:0] a, b, hi, lo, eR, eH, eL;
    logic [4:0]  sh;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 25)];
      a = pickOperand(); b = pickOperand(); hi = $urandom; lo = $urandom;
      sh = 5'($urandom);
      model(op, a, b, hi, lo, sh, eR, eH, eL);
      apply(op, a, b, sh, hi, lo);
      nChecks++;
      if (ALUResult_OUT !== eR || HI_OUT !== eH || LO_OUT !== eL) begin
        nFails++;
        $display("FAIL random op=%b a=%h b=%h sh=%0d: got %h %h %h want %h %h %h",
                 op, a, b, sh, ALUResult_OUT, HI_OUT, LO_OUT, eR, eH, eL);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shifts();
    test_compare_lui();
    test_mult();
    test_div();
    test_moves();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Registered 32-bit integer ALU for the EXE stage of the five-stage MIPS pipeline. It takes two forwarded operands, a 6-bit operation code, a shift amount and the current HI/LO values. It computes a 32-bit result plus next HI/LO values. All three outputs are registered on the rising clock edge, and the EXE stage writes HI/LO back from `HI_OUT`/`LO_OUT`.

## Interface
No parameters.
- `CLOCK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high; clears all output registers.
- `HI_IN` in 32: current HI register value.
- `LO_IN` in 32: current LO register value.
- `OperandA_IN` in 32: operand A (rs after forwarding).
- `OperandB_IN` in 32: operand B (rt or immediate after forwarding).
- `ALUControl_IN` in 6: operation select (encoding below).
- `ShiftAmount_IN` in 5: shamt for fixed shifts.
- `ALUResult_OUT` out 32: registered result.
- `HI_OUT` out 32: registered next HI.
- `LO_OUT` out 32: registered next LO.

## Operation
- A = `OperandA_IN`, B = `OperandB_IN`.
- Default: result 0, next HI = `HI_IN`, next LO = `LO_IN`.
- Codes 000000–000111 (shifts; B is the shifted value):
  - 000000 SLL: B << shamt.
  - 000010 SRL: B >> shamt, logical.
  - 000011 SRA: B >> shamt, arithmetic.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: as the fixed shifts, with amount A[4:0].
- 001111 LUI: {B[15:0], 16'h0}.
- Codes 010000–010011 (HI/LO moves):
  - 010000 MFHI: result = `HI_IN`.
  - 010001 MTHI: next HI = A.
  - 010010 MFLO: result = `LO_IN`.
  - 010011 MTLO: next LO = A.
- Codes 011000–011011 (multiply/divide; result 0):
  - 011000 MULT: {HI,LO} = signed 64-bit A*B.
  - 011001 MULTU: {HI,LO} = unsigned 64-bit A*B.
  - 011010 DIV: LO = signed quotient, HI = signed remainder.
    - Truncation toward zero; remainder takes the sign of A.
  - 011011 DIVU: LO = unsigned quotient, HI = unsigned remainder.
  - Divide by zero (DIV and DIVU): LO = 32'hFFFFFFFF, HI = A.
  - DIV with A = 32'h80000000 and B = 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- Codes 100000–101011 (arithmetic/logic):
  - 100000 ADD, 100001 ADDU: A + B mod 2^32; ADD has no overflow trap.
  - 100010 SUB, 100011 SUBU: A − B mod 2^32.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise.
  - 101010 SLT: 1 if A < B signed, else 0.
  - 101011 SLTU: 1 if A < B unsigned, else 0.
- Any other code: default values (result 0, HI/LO passed through unchanged).
- All arithmetic is on 32-bit operands. 64-bit products are split with HI = [63:32], LO = [31:0].

## Timing
- Next-state logic is fully combinational from the inputs.
- `ALUResult_OUT`, `HI_OUT`, `LO_OUT` update on every rising `CLOCK` edge: one-cycle latency, new operation accepted every cycle, no handshake, no stall.
- `RESET` high forces all three outputs to 0 immediately, without waiting for a clock edge, and holds them at 0 while asserted.
- Clock edges while `RESET` is high have no effect.
- First rising edge after `RESET` deasserts loads the current operation.
- Multiply and divide complete in a single cycle (combinational array); no busy state.
- An unused HI/LO field simply re-registers `HI_IN`/`LO_IN`, so feeding `HI_OUT`/`LO_OUT` back to `HI_IN`/`LO_IN` holds the values.

## Test plan
- Reset and ADD:
  - Assert `RESET` mid-cycle → all outputs 0 with no clock edge.
  - Release; ADD A=32'h7FFFFFFF, B=1 → after 1 edge result 32'h80000000, HI/LO equal `HI_IN`/`LO_IN`.
- Shifts, B=32'h80000010, shamt=4:
  - SLL → 32'h00000100; SRL → 32'h08000001; SRA → 32'hF8000001.
  - SRAV with A=36 (A[4:0]=4) → same as SRA.
- Compares, A=32'hFFFFFFFF, B=1: SLT → 1, SLTU → 0. LUI with B=32'h0000ABCD → 32'hABCD0000.
- Multiply, A=32'hFFFFFFFE, B=3:
  - MULT → HI 32'hFFFFFFFF, LO 32'hFFFFFFFA.
  - MULTU → HI 2, LO 32'hFFFFFFFA.
  - Result 0 for both.
- Divide:
  - DIV A=−7, B=2 → LO 32'hFFFFFFFD, HI 32'hFFFFFFFF.
  - DIVU A=7, B=0 → LO 32'hFFFFFFFF, HI 7.
  - DIV 32'h80000000 / 32'hFFFFFFFF → LO 32'h80000000, HI 0.
- Moves and undefined code:
  - MTHI A=5 → HI_OUT 5, LO passes through.
  - MFLO with LO_IN=9 → result 9.
  - Code 111111 → result 0, HI/LO pass through.
